// File: rtl/hci_router_resp_buffer.sv
// hci_router_resp_buffer
//
// Sits in front of the HCI reorder router. Splits one wide word-aligned access into NB_CHAN
// per-channel TCDM requests and derives the router rotation from the address. It captures
// the router's latency-1 read responses in a FIFO, and returns them to the master through a
// valid/ready handshake. A read is only issued when a FIFO slot is guaranteed for its response.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous flush of FIFO and in-flight tracking
//   req_i, add_i, wen_i,   master request (wen_i = 1 is a read), byte address of channel 0,
//   be_i, data_i           per-channel byte enables and write data
//   gnt_o                  request accepted this cycle
//   r_valid_o, r_data_o,   response word handshake towards the master
//   r_ready_i
//   order_o                router rotation
//   tcdm_*_o               per-channel request towards the router
//   tcdm_gnt_i, tcdm_r_*   router grant and response (channel 0 is representative)
//   unexpected_o           router response with no grant in the previous cycle
module hci_router_resp_buffer #(
    parameter int unsigned NB_CHAN = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      req_i,
    input  logic [ADDR_W-1:0]         add_i,
    input  logic                      wen_i,
    input  logic [NB_CHAN*4-1:0]      be_i,
    input  logic [NB_CHAN*32-1:0]     data_i,
    output logic                      gnt_o,
    output logic                      r_valid_o,
    output logic [NB_CHAN*32-1:0]     r_data_o,
    input  logic                      r_ready_i,
    output logic [$clog2(NB_CHAN)-1:0] order_o,
    output logic                      tcdm_req_o,
    output logic [NB_CHAN*ADDR_W-1:0] tcdm_add_o,
    output logic                      tcdm_wen_o,
    output logic [NB_CHAN*4-1:0]      tcdm_be_o,
    output logic [NB_CHAN*32-1:0]     tcdm_data_o,
    input  logic                      tcdm_gnt_i,
    input  logic                      tcdm_r_valid_i,
    input  logic [NB_CHAN*32-1:0]     tcdm_r_data_i,
    output logic                      unexpected_o
);

    localparam int unsigned OrdW  = $clog2(NB_CHAN);
    localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam int unsigned DataW = NB_CHAN * 32;

    logic [DataW-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             pend_rd_q;  // read granted last cycle, response due now
    logic             gnt_q;      // any grant last cycle
    logic             clr_q;      // clear last cycle: its late response is silently dropped

    logic [ADDR_W-1:0] base_addr;
    logic [CntW:0]     used_slots;
    logic              credit_ok;
    logic              push, pop;
    logic              unused_add_lsb;

    // Address split: channel i sees the word-aligned base plus 4*i, wrapping at 2^ADDR_W.
    assign base_addr      = {add_i[ADDR_W-1:2], 2'b00};
    assign unused_add_lsb = ^add_i[1:0];

    for (genvar i = 0; i < NB_CHAN; i++) begin : g_chan_addr
        assign tcdm_add_o[i*ADDR_W +: ADDR_W] = base_addr + ADDR_W'(4 * i);
    end

    assign order_o     = add_i[2 +: OrdW];
    assign tcdm_wen_o  = wen_i;
    assign tcdm_be_o   = be_i;
    assign tcdm_data_o = data_i;

    // A read reserves a slot for its response; the in-flight read already holds one.
    assign used_slots = {1'b0, count_q} + (CntW + 1)'(pend_rd_q);
    assign credit_ok  = ~wen_i | (used_slots < (CntW + 1)'(DEPTH));
    assign tcdm_req_o = req_i & credit_ok;
    assign gnt_o      = tcdm_req_o & tcdm_gnt_i;

    assign push = tcdm_r_valid_i & pend_rd_q & ~clear_i;
    assign r_valid_o = (count_q != '0);
    assign pop       = r_valid_o & r_ready_i;
    assign r_data_o  = mem_q[rd_ptr_q];

    assign unexpected_o = tcdm_r_valid_i & ~gnt_q & ~clr_q & ~clear_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pend_rd_q <= 1'b0;
            gnt_q     <= 1'b0;
            clr_q     <= 1'b0;
        end else if (clear_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pend_rd_q <= 1'b0;
            gnt_q     <= 1'b0;
            clr_q     <= 1'b1;
        end else begin
            pend_rd_q <= gnt_o & wen_i;
            gnt_q     <= gnt_o;
            clr_q     <= 1'b0;
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tcdm_r_data_i;
        end
    end

endmodule
